// File: rtl/ctr_pkg.sv
// Shared types and defaults for the counter-sequence checker.
package ctr_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int unsigned CTR_WIDTH       = 8;
    localparam int unsigned LOCK_RUN_DEF    = 4;
    localparam int unsigned UNLOCK_ERRS_DEF = 3;
    localparam int unsigned ERR_W_DEF       = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear beats increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ctr_seq_checker.sv
// Locks onto a wrapping increment sequence on data_in and flags/counts
// out-of-sequence samples while locked.
module ctr_seq_checker
    import ctr_pkg::*;
#(
    parameter int unsigned WIDTH       = CTR_WIDTH,
    parameter int unsigned LOCK_RUN    = LOCK_RUN_DEF,
    parameter int unsigned UNLOCK_ERRS = UNLOCK_ERRS_DEF,
    parameter int unsigned ERR_W       = ERR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] data_in,
    output logic             locked,
    output logic             err_pulse,
    output logic             sticky_err,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] last_bad
);

    localparam logic [7:0] LOCK_RUN_C    = 8'(LOCK_RUN);
    localparam logic [7:0] UNLOCK_ERRS_C = 8'(UNLOCK_ERRS);

    state_t           state;
    logic             seeded;
    logic [WIDTH-1:0] expected;
    logic [7:0]       run;
    logic [7:0]       bad_run;

    logic       hit;
    logic       miss_locked;
    logic [7:0] run_inc;
    logic [7:0] bad_inc;

    always_comb begin
        hit         = (data_in == expected);
        miss_locked = sample_en && (state == LOCKED) && !hit;
        run_inc     = run + 8'd1;
        bad_inc     = bad_run + 8'd1;
    end

    assign locked = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SEARCH;
            seeded     <= 1'b0;
            expected   <= '0;
            run        <= '0;
            bad_run    <= '0;
            err_pulse  <= 1'b0;
            sticky_err <= 1'b0;
            last_bad   <= '0;
        end else begin
            err_pulse <= miss_locked;
            if (miss_locked) begin
                last_bad <= data_in;
            end
            if (clr) begin
                sticky_err <= 1'b0;
            end else if (miss_locked) begin
                sticky_err <= 1'b1;
            end

            if (sample_en) begin
                if (state == SEARCH) begin
                    if (!seeded) begin
                        seeded   <= 1'b1;
                        expected <= data_in + 1'b1;
                        run      <= '0;
                    end else if (hit) begin
                        expected <= expected + 1'b1;
                        run      <= run_inc;
                        if (run_inc == LOCK_RUN_C) begin
                            state   <= LOCKED;
                            bad_run <= '0;
                        end
                    end else begin
                        run      <= '0;
                        expected <= data_in + 1'b1;
                    end
                end else begin
                    // Keep predicting from the locked sequence even on bad data.
                    expected <= expected + 1'b1;
                    if (hit) begin
                        bad_run <= '0;
                    end else begin
                        bad_run <= bad_inc;
                        if (bad_inc == UNLOCK_ERRS_C) begin
                            state  <= SEARCH;
                            seeded <= 1'b0;
                            run    <= '0;
                        end
                    end
                end
            end
        end
    end

    sat_counter #(
        .W (ERR_W)
    ) u_err_count (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (miss_locked),
        .count (err_count)
    );

endmodule

// File: tb/tb_ctr_seq_checker.sv
// Scoreboard bench for ctr_seq_checker: directed scenarios plus random stream.
module tb_ctr_seq_checker;

    localparam int W  = 8;
    localparam int LR = 4;
    localparam int UE = 3;
    localparam int EW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          sample_en = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic          locked;
    logic          err_pulse;
    logic          sticky_err;
    logic [EW-1:0] err_count;
    logic [W-1:0]  last_bad;

    always #5 clk = ~clk;

    ctr_seq_checker #(
        .WIDTH       (W),
        .LOCK_RUN    (LR),
        .UNLOCK_ERRS (UE),
        .ERR_W       (EW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .sample_en  (sample_en),
        .data_in    (data_in),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .sticky_err (sticky_err),
        .err_count  (err_count),
        .last_bad   (last_bad)
    );

    typedef struct packed {
        logic          locked;
        logic          pulse;
        logic          sticky;
        logic [EW-1:0] cnt;
        logic [W-1:0]  last;
    } resp_t;

    resp_t sb[$];
    int    checks = 0;
    int    passed = 0;

    // Reference model: plain integer bookkeeping of the sequence rules.
    bit m_locked, m_seeded, m_sticky, m_pulse;
    int m_exp, m_run, m_bad, m_cnt, m_last;
    localparam int CNT_MAX = (1 << EW) - 1;

    task automatic model_step(input bit r, input bit c, input bit e, input int d);
        resp_t x;
        if (r) begin
            m_locked = 0; m_seeded = 0; m_sticky = 0; m_pulse = 0;
            m_exp = 0; m_run = 0; m_bad = 0; m_cnt = 0; m_last = 0;
        end else begin
            m_pulse = 0;
            if (e) begin
                if (!m_locked) begin
                    if (!m_seeded) begin
                        m_seeded = 1;
                        m_exp = (d + 1) % 256;
                        m_run = 0;
                    end else if (d == m_exp) begin
                        m_run++;
                        m_exp = (m_exp + 1) % 256;
                        if (m_run == LR) begin
                            m_locked = 1;
                            m_bad = 0;
                        end
                    end else begin
                        m_run = 0;
                        m_exp = (d + 1) % 256;
                    end
                end else begin
                    if (d == m_exp) begin
                        m_bad = 0;
                    end else begin
                        m_pulse = 1;
                        m_sticky = 1;
                        m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
                        m_last = d;
                        m_bad++;
                        if (m_bad == UE) begin
                            m_locked = 0;
                            m_seeded = 0;
                            m_run = 0;
                        end
                    end
                    m_exp = (m_exp + 1) % 256;
                end
            end
            if (c) begin
                m_cnt = 0;
                m_sticky = 0;
            end
        end
        x.locked = m_locked;
        x.pulse  = m_pulse;
        x.sticky = m_sticky;
        x.cnt    = EW'(m_cnt);
        x.last   = W'(m_last);
        sb.push_back(x);
    endtask

    task automatic drive(input bit r, input bit c, input bit e, input int d);
        @(negedge clk);
        rst       = r;
        clr       = c;
        sample_en = e;
        data_in   = W'(d);
        model_step(r, c, e, d);
    endtask

    task automatic feed(input int v);
        drive(0, 0, 1, v % 256);
    endtask

    task automatic feed_run(input int start, input int n);
        for (int i = 0; i < n; i++) feed(start + i);
    endtask

    resp_t mon_e, mon_a;
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            mon_a = {locked, err_pulse, sticky_err, err_count, last_bad};
            checks++;
            if (mon_a === mon_e)
                passed++;
            else
                $display("FAIL cycle t=%0t got locked=%0b pulse=%0b sticky=%0b cnt=%0d last=%02h want locked=%0b pulse=%0b sticky=%0b cnt=%0d last=%02h",
                         $time, mon_a.locked, mon_a.pulse, mon_a.sticky, mon_a.cnt, mon_a.last,
                         mon_e.locked, mon_e.pulse, mon_e.sticky, mon_e.cnt, mon_e.last);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int guard;
        drive(1, 0, 0, 0);
        drive(1, 0, 1, 8'h33);

        // Lock on 0x10..0x14.
        feed_run(8'h10, 5);
        feed_run(8'h15, 2);

        // Lock just before the 0xFF wrap and run through it.
        drive(1, 0, 0, 0);
        feed_run(8'hF9, 5);
        feed_run(8'hFE, 4);

        // Single bad sample at expected 0x20.
        drive(1, 0, 0, 0);
        feed_run(8'h1B, 5);
        feed(8'h55);
        feed(8'h21);

        // Three consecutive errors unlock, then relock.
        feed_run(8'h22, 14);
        feed(0); feed(0); feed(0);
        feed_run(8'h40, 5);

        // Stall with garbage on data_in.
        for (int i = 0; i < 10; i++) drive(0, 0, 0, $urandom_range(0, 255));
        feed(8'h45);

        // Saturate the 4-bit error counter with alternating bad/good.
        for (int i = 0; i < (1 << EW) + 2; i++) begin
            feed((m_exp + 128) % 256);
            feed(m_exp);
        end
        drive(0, 1, 1, (m_exp + 7) % 256);
        feed(m_exp);
        feed(m_exp);
        drive(1, 0, 1, m_exp);
        drive(0, 0, 0, 0);

        // Randomized stream.
        for (int i = 0; i < 700; i++) begin
            bit r, c, e;
            int d;
            r = ($urandom_range(0, 149) == 0);
            c = ($urandom_range(0, 59) == 0);
            e = ($urandom_range(0, 9) < 8);
            d = ($urandom_range(0, 4) != 0) ? m_exp : int'($urandom_range(0, 255));
            drive(r, c, e, d);
        end

        drive(0, 0, 0, 0);
        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
